// File: rtl/pwm_decoder.sv
// PWM receiver: measures high time and period of pwm_in in prescaled ticks.
// Optional 3-tap majority glitch filter when PWM_DECODER_GLITCH_FILTER_EN is defined.
module pwm_decoder #(
   parameter int TICK_DIV = 128,
   parameter int CNT_W    = 9
) (
   input  logic             CLK,
   input  logic             CPU_RESETN,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] high_ticks,
   output logic [CNT_W-1:0] period_ticks,
   output logic             valid,
   output logic             stuck,
   output logic             level
);
   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, MEASURE, STUCK} state_t;

   state_t           state_q, state_d;
   logic             sync1_q, sync2_q;
   logic [DIV_W-1:0] div_q, div_d;
   logic             samp_q, samp_d;
   logic [CNT_W-1:0] pcnt_q, pcnt_d, hcnt_q, hcnt_d;
   logic [CNT_W-1:0] high_q, high_d, per_q, per_d;
   logic             valid_q, valid_d, stuck_q, stuck_d;
   logic             tick, samp_new, rise;
   logic [CNT_W-1:0] pcnt_inc, hcnt_inc;

`ifdef PWM_DECODER_GLITCH_FILTER_EN
   logic [1:0] tap_q, tap_d;
   assign samp_new = (sync2_q & tap_q[0]) | (sync2_q & tap_q[1]) | (tap_q[0] & tap_q[1]);
   assign tap_d    = tick ? {tap_q[0], sync2_q} : tap_q;
   always_ff @(posedge CLK) begin
      if (!CPU_RESETN) tap_q <= '0;
      else             tap_q <= tap_d;
   end
`else
   assign samp_new = sync2_q;
`endif

   assign tick     = (div_q == DIV_LAST);
   assign rise     = tick & samp_new & ~samp_q;
   assign pcnt_inc = (pcnt_q == CNT_MAX) ? pcnt_q : pcnt_q + 1'b1;
   assign hcnt_inc = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + 1'b1;

   always_ff @(posedge CLK) begin
      if (!CPU_RESETN) begin
         state_q <= IDLE;
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         div_q   <= '0;
         samp_q  <= 1'b0;
         pcnt_q  <= '0;
         hcnt_q  <= '0;
         high_q  <= '0;
         per_q   <= '0;
         valid_q <= 1'b0;
         stuck_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sync1_q <= pwm_in;
         sync2_q <= sync1_q;
         div_q   <= div_d;
         samp_q  <= samp_d;
         pcnt_q  <= pcnt_d;
         hcnt_q  <= hcnt_d;
         high_q  <= high_d;
         per_q   <= per_d;
         valid_q <= valid_d;
         stuck_q <= stuck_d;
      end
   end

   always_comb begin
      state_d = state_q;
      div_d   = tick ? '0 : div_q + 1'b1;
      samp_d  = tick ? samp_new : samp_q;
      pcnt_d  = pcnt_q;
      hcnt_d  = hcnt_q;
      high_d  = high_q;
      per_d   = per_q;
      valid_d = 1'b0;
      stuck_d = stuck_q;
      if (tick) begin
         unique case (state_q)
            IDLE, STUCK: begin
               if (rise) begin
                  pcnt_d  = CNT_ONE;
                  hcnt_d  = CNT_ONE;
                  state_d = MEASURE;
               end
            end
            MEASURE: begin
               if (rise) begin
                  high_d  = hcnt_q;
                  per_d   = pcnt_q;
                  valid_d = 1'b1;
                  stuck_d = 1'b0;
                  pcnt_d  = CNT_ONE;
                  hcnt_d  = CNT_ONE;
               end else begin
                  pcnt_d = pcnt_inc;
                  if (samp_new) hcnt_d = hcnt_inc;
                  // Period can no longer be published: report zeros once and flag stuck
                  if (pcnt_inc == CNT_MAX) begin
                     high_d  = '0;
                     per_d   = '0;
                     valid_d = 1'b1;
                     stuck_d = 1'b1;
                     state_d = STUCK;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign high_ticks   = high_q;
   assign period_ticks = per_q;
   assign valid        = valid_q;
   assign stuck        = stuck_q;
   assign level        = samp_q;
endmodule

// File: tb/tb_pwm_decoder.sv
// Directed bench for pwm_decoder: tick-aligned table at TICK_DIV=1 plus a TICK_DIV=4 instance.
module tb_pwm_decoder;
   localparam int CNT_W = 9;

   logic             CLK = 1'b0;
   logic             CPU_RESETN = 1'b0;
   logic             pwm_in = 1'b0;
   logic             pwm4 = 1'b0;
   logic [CNT_W-1:0] high_ticks, period_ticks, high4, per4;
   logic             valid, stuck, level, valid4, stuck4, level4;

   always #5 CLK = ~CLK;

   pwm_decoder #(.TICK_DIV(1), .CNT_W(CNT_W)) u_dut (
      .CLK(CLK), .CPU_RESETN(CPU_RESETN), .pwm_in(pwm_in),
      .high_ticks(high_ticks), .period_ticks(period_ticks),
      .valid(valid), .stuck(stuck), .level(level));

   pwm_decoder #(.TICK_DIV(4), .CNT_W(CNT_W)) u_dut4 (
      .CLK(CLK), .CPU_RESETN(CPU_RESETN), .pwm_in(pwm4),
      .high_ticks(high4), .period_ticks(per4),
      .valid(valid4), .stuck(stuck4), .level(level4));

   int tests = 0, fails = 0;
   int vtot = 0, vwide = 0, v4tot = 0, vbase = 0;
   int cap_high = 0, cap_per = 0, cap_stuck = 0, cap4_high = 0, cap4_per = 0;
   logic vprev = 1'b0;

   always @(negedge CLK) begin
      vprev <= valid;
      if (valid) begin
         vtot      <= vtot + 1;
         cap_high  <= int'(high_ticks);
         cap_per   <= int'(period_ticks);
         cap_stuck <= int'(stuck);
         if (vprev) vwide <= vwide + 1;
      end
      if (valid4) begin
         v4tot     <= v4tot + 1;
         cap4_high <= int'(high4);
         cap4_per  <= int'(per4);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_rng(input string name, input int act, input int lo, input int hi);
      tests++;
      if (act < lo || act > hi) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Compare the reports seen since the last call; fields only checked when a report is expected
   task automatic chk_rep(input string name, input int n, input int h, input int p, input int s);
      chk({name, ".count"}, vtot - vbase, n);
      if (n > 0) begin
         chk({name, ".high"}, cap_high, h);
         chk({name, ".period"}, cap_per, p);
         chk({name, ".stuck"}, cap_stuck, s);
      end
      vbase = vtot;
   endtask

   task automatic drive(input int h, input int l);
      for (int i = 0; i < h + l; i++) begin
         @(posedge CLK); #1;
         pwm_in = (i < h);
      end
      @(negedge CLK); #1;
   endtask

   typedef struct {
      int h; int l; int exp_n; int exp_h; int exp_p;
   } vec_t;
   vec_t vecs[12];

   initial begin
      // each row drives one period; expected values are the report of the previous period
      vecs[0]  = '{100, 156, 0,   0,   0};
      vecs[1]  = '{100, 156, 1, 100, 256};
      vecs[2]  = '{100, 156, 1, 100, 256};
      vecs[3]  = '{105, 151, 1, 100, 256};
      vecs[4]  = '{ 95, 161, 1, 105, 256};
      vecs[5]  = '{ 95, 161, 1,  95, 256};
      vecs[6]  = '{ 10,  20, 1,  95, 256};
      vecs[7]  = '{  2,   3, 1,  10,  30};
      vecs[8]  = '{100, 156, 1,   2,   5};
      vecs[9]  = '{200, 310, 1, 100, 256};
      vecs[10] = '{100, 156, 1, 200, 510};
      vecs[11] = '{100, 156, 1, 100, 256};

      repeat (3) @(posedge CLK);
      #1 CPU_RESETN = 1'b1;
      @(negedge CLK); #1;
      chk("rst.high", int'(high_ticks), 0);
      chk("rst.period", int'(period_ticks), 0);
      chk("rst.valid", int'(valid), 0);
      chk("rst.stuck", int'(stuck), 0);
      chk("rst.level", int'(level), 0);
      chk("rst4.outs", int'({high4, per4, valid4, stuck4, level4}), 0);

      for (int k = 0; k < 12; k++) begin
         drive(vecs[k].h, vecs[k].l);
         chk_rep($sformatf("vec%0d", k), vecs[k].exp_n, vecs[k].exp_h, vecs[k].exp_p, 0);
      end

      // reset mid-high of an H=50 period, released during the low phase
      for (int i = 0; i < 256; i++) begin
         @(posedge CLK); #1;
         pwm_in = (i < 50);
         if (i == 20) CPU_RESETN = 1'b0;
         if (i == 21) begin
            chk("midrst.high", int'(high_ticks), 0);
            chk("midrst.period", int'(period_ticks), 0);
            chk("midrst.valid", int'(valid), 0);
            chk("midrst.level", int'(level), 0);
         end
         if (i == 70) CPU_RESETN = 1'b1;
      end
      chk_rep("pre_rst", 1, 100, 256, 0);
      drive(50, 206);
      chk_rep("post_rst.edge1", 0, 0, 0, 0);
      drive(50, 206);
      chk_rep("post_rst.edge2", 1, 50, 256, 0);

      drive(100, 156);
      chk_rep("pre_glitch", 1, 50, 256, 0);
      drive(50, 1);
      drive(49, 156);
`ifdef PWM_DECODER_GLITCH_FILTER_EN
      chk_rep("glitch", 1, 100, 256, 0);
      drive(100, 156);
      chk_rep("post_glitch", 1, 100, 256, 0);
`else
      chk_rep("glitch", 2, 50, 51, 0);
      drive(100, 156);
      chk_rep("post_glitch", 1, 49, 205, 0);
`endif

      drive(100, 600);
      chk_rep("stuck_entry", 2, 0, 0, 1);
      chk("stuck.flag", int'(stuck), 1);
      chk("stuck.level", int'(level), 0);
      chk("stuck.period", int'(period_ticks), 0);
      drive(100, 156);
      chk_rep("stuck_edge1", 0, 0, 0, 0);
      chk("stuck.hold", int'(stuck), 1);
      drive(100, 156);
      chk_rep("stuck_clear", 1, 100, 256, 0);
      chk("stuck.cleared", int'(stuck), 0);

      chk("valid_width", vwide, 0);
      chk("div4.idle", v4tot, 0);

      for (int p = 0; p < 3; p++)
         for (int i = 0; i < 1024; i++) begin
            @(posedge CLK); #1;
            pwm4 = (i < 512);
         end
      @(negedge CLK); #1;
      chk("div4.count", v4tot, 2);
      chk_rng("div4.high", cap4_high, 127, 129);
      chk_rng("div4.period", cap4_per, 255, 257);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete, expected finish");
      $fatal(1);
   end
endmodule
